// File: rtl/compare_pkg.sv
// Shared encodings for the comparator decision stage: result triple, FSM states,
// counter width and the one-hot legality check.
package compare_pkg;

  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_LESS    = 3'b100;
  localparam cmp_res_t CMP_EQUAL   = 3'b010;
  localparam cmp_res_t CMP_GREATER = 3'b001;

  localparam int CHANGE_CNT_W = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // A comparator result is legal only when exactly one flag is set.
  function automatic logic is_onehot(input cmp_res_t res);
    return (res == CMP_LESS) || (res == CMP_EQUAL) || (res == CMP_GREATER);
  endfunction

endpackage

// File: rtl/compare_debounce_if.sv
// Comparator flag inputs and debounced decision outputs of compare_debounce.
// The master side drives the flags; the slave side is the debounce stage.
interface compare_debounce_if;
  import compare_pkg::*;

  logic                    in_valid;
  logic                    a_less_b;
  logic                    a_equal_b;
  logic                    a_greater_b;
  logic                    stable_valid;
  logic                    stable_less;
  logic                    stable_equal;
  logic                    stable_greater;
  logic                    change_pulse;
  logic [CHANGE_CNT_W-1:0] change_count;
  logic                    err_flag;

  modport master (
    output in_valid, a_less_b, a_equal_b, a_greater_b,
    input  stable_valid, stable_less, stable_equal, stable_greater,
    input  change_pulse, change_count, err_flag
  );

  modport slave (
    input  in_valid, a_less_b, a_equal_b, a_greater_b,
    output stable_valid, stable_less, stable_equal, stable_greater,
    output change_pulse, change_count, err_flag
  );

endinterface

// File: rtl/compare_run_counter.sv
// Candidate register and saturating run-length counter; reached_o strobes on the
// legal sample whose post-update run length first equals STABLE_COUNT.
module compare_run_counter
  import compare_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     sample_vld_i,
  input  cmp_res_t sample_i,
  output cmp_res_t cand_next_o,
  output logic     reached_o,
  output logic     illegal_o
);

  localparam logic [3:0] RUN_TARGET = 4'(STABLE_COUNT);
  localparam logic [3:0] RUN_MAX    = 4'd15;

  cmp_res_t   cand_q, cand_d;
  logic [3:0] run_q, run_d;
  logic       legal_s;
  logic       match_s;
  logic       sat_hold_s;

  // Next candidate/run length; a saturated run holds and must not re-trigger.
  always_comb begin
    cand_d     = cand_q;
    run_d      = run_q;
    sat_hold_s = 1'b0;
    legal_s    = sample_vld_i && is_onehot(sample_i);
    match_s    = (sample_i == cand_q) && (run_q != 4'd0);
    if (sample_vld_i) begin
      if (!is_onehot(sample_i)) begin
        run_d = 4'd0;
      end else if (match_s) begin
        if (run_q == RUN_MAX) begin
          sat_hold_s = 1'b1;
        end else begin
          run_d = run_q + 4'd1;
        end
      end else begin
        cand_d = sample_i;
        run_d  = 4'd1;
      end
    end else begin
      run_d = run_q;
    end
  end

  // Candidate and run-length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= 3'b000;
      run_q  <= 4'd0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end

  assign cand_next_o = cand_d;
  assign reached_o   = legal_s && !sat_hold_s && (run_d == RUN_TARGET);
  assign illegal_o   = sample_vld_i && !is_onehot(sample_i);

endmodule

// File: rtl/compare_debounce.sv
// Debounced decision stage behind the 2-bit magnitude comparator.
// Define COMPARE_DEBOUNCE_ERR_EN to build the sticky non-one-hot err_flag.
module compare_debounce
  import compare_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  compare_debounce_if.slave   bus
);

  localparam logic [CHANGE_CNT_W-1:0] CNT_MAX = {CHANGE_CNT_W{1'b1}};

  cmp_res_t                sample_s;
  cmp_res_t                cand_next_s;
  logic                    reached_s;
  logic                    illegal_s;

  lock_state_t             state_q, state_d;
  cmp_res_t                stable_q, stable_d;
  logic                    valid_q, valid_d;
  logic                    pulse_q, pulse_d;
  logic [CHANGE_CNT_W-1:0] count_q, count_d;

  assign sample_s = {bus.a_less_b, bus.a_equal_b, bus.a_greater_b};

  compare_run_counter #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_run_counter (
    .clk          (clk),
    .reset        (reset),
    .sample_vld_i (bus.in_valid),
    .sample_i     (sample_s),
    .cand_next_o  (cand_next_s),
    .reached_o    (reached_s),
    .illegal_o    (illegal_s)
  );

  // Lock/change decision; a reached run only counts if it differs from the held value.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    count_d  = count_q;
    case (state_q)
      UNLOCKED: begin
        if (reached_s) begin
          state_d  = LOCKED;
          stable_d = cand_next_s;
          pulse_d  = 1'b1;
        end else begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (reached_s && (cand_next_s != stable_q)) begin
          stable_d = cand_next_s;
          pulse_d  = 1'b1;
        end else begin
          stable_d = stable_q;
        end
      end
      default: begin
        state_d  = UNLOCKED;
        stable_d = 3'b000;
      end
    endcase
    if (pulse_d && (count_q != CNT_MAX)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
    valid_d = (state_d == LOCKED);
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      stable_q <= 3'b000;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
    end
  end

  assign bus.stable_valid   = valid_q;
  assign bus.stable_less    = stable_q[2];
  assign bus.stable_equal   = stable_q[1];
  assign bus.stable_greater = stable_q[0];
  assign bus.change_pulse   = pulse_q;
  assign bus.change_count   = count_q;

`ifdef COMPARE_DEBOUNCE_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | illegal_s;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_flag = err_q;
`else
  logic unused_illegal_s;
  assign unused_illegal_s = illegal_s;
  assign bus.err_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_compare_debounce.sv
// Bench for compare_debounce: STABLE_COUNT=4 and =1 instances share stimulus and
// are compared each cycle against a history-based reference model.
module tb_compare_debounce;
  import compare_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  compare_debounce_if bus4 ();
  compare_debounce_if bus1 ();

  compare_debounce #(.STABLE_COUNT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  compare_debounce #(.STABLE_COUNT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: legal samples since the last reset/illegal sample.
  cmp_res_t    hist[$];
  int          sc_tab[2] = '{4, 1};
  logic        m_valid[2];
  cmp_res_t    m_stable[2];
  logic        m_pulse[2];
  logic [7:0]  m_count[2];
  logic        m_err;

  typedef struct {
    logic     rst;
    logic     v;
    cmp_res_t s;
    logic     e_valid;
    cmp_res_t e_stable;
    logic     e_pulse;
    logic [7:0] e_count;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step(input logic rst, input logic v, input cmp_res_t s);
    int run;
    for (int i = 0; i < 2; i++) m_pulse[i] = 1'b0;
    if (rst) begin
      hist.delete();
      m_err = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0; m_stable[i] = 3'b000; m_count[i] = 8'd0;
      end
    end else if (v) begin
      if ($countones(s) == 1) begin
        hist.push_back(s);
        if (hist.size() > 20) void'(hist.pop_front());
        run = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
          if (hist[k] != s) break;
          run++;
        end
        for (int i = 0; i < 2; i++) begin
          if (run == sc_tab[i] && (!m_valid[i] || m_stable[i] != s)) begin
            m_valid[i]  = 1'b1;
            m_stable[i] = s;
            m_pulse[i]  = 1'b1;
            if (m_count[i] != 8'd255) m_count[i] = m_count[i] + 8'd1;
          end
        end
      end else begin
        hist.delete();
        m_err = 1'b1;
      end
    end
  endtask

  function automatic logic exp_err();
`ifdef COMPARE_DEBOUNCE_ERR_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_model();
    logic [13:0] a4, a1, e4, e1;
    a4 = {bus4.stable_valid, bus4.stable_less, bus4.stable_equal, bus4.stable_greater,
          bus4.change_pulse, bus4.change_count, bus4.err_flag};
    a1 = {bus1.stable_valid, bus1.stable_less, bus1.stable_equal, bus1.stable_greater,
          bus1.change_pulse, bus1.change_count, bus1.err_flag};
    e4 = {m_valid[0], m_stable[0], m_pulse[0], m_count[0], exp_err()};
    e1 = {m_valid[1], m_stable[1], m_pulse[1], m_count[1], exp_err()};
    check("model_sc4", 32'(a4), 32'(e4));
    check("model_sc1", 32'(a1), 32'(e1));
  endtask

  task automatic drive(input logic rst, input logic v, input cmp_res_t s);
    reset = rst;
    bus4.in_valid = v;
    bus1.in_valid = v;
    {bus4.a_less_b, bus4.a_equal_b, bus4.a_greater_b} = s;
    {bus1.a_less_b, bus1.a_equal_b, bus1.a_greater_b} = s;
    @(posedge clk);
    model_step(rst, v, s);
    #1;
    check_model();
  endtask

  initial begin
    cmp_res_t prev;
    cmp_res_t pick;
    int r;
    logic [12:0] act;

    tbl[0]  = '{1'b1, 1'b0, CMP_LESS,    1'b0, 3'b000,      1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, CMP_EQUAL,   1'b0, 3'b000,      1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, CMP_EQUAL,   1'b0, 3'b000,      1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, CMP_EQUAL,   1'b0, 3'b000,      1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, CMP_EQUAL,   1'b1, CMP_EQUAL,   1'b1, 8'd1};
    tbl[5]  = '{1'b0, 1'b1, CMP_LESS,    1'b1, CMP_EQUAL,   1'b0, 8'd1};
    tbl[6]  = '{1'b0, 1'b1, CMP_LESS,    1'b1, CMP_EQUAL,   1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b1, CMP_LESS,    1'b1, CMP_EQUAL,   1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b1, CMP_GREATER, 1'b1, CMP_EQUAL,   1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b1, CMP_LESS,    1'b1, CMP_EQUAL,   1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b1, CMP_LESS,    1'b1, CMP_EQUAL,   1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b1, CMP_LESS,    1'b1, CMP_EQUAL,   1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b1, CMP_LESS,    1'b1, CMP_LESS,    1'b1, 8'd2};
    tbl[13] = '{1'b0, 1'b0, CMP_GREATER, 1'b1, CMP_LESS,    1'b0, 8'd2};

    reset = 1'b1;
    bus4.in_valid = 1'b0; bus1.in_valid = 1'b0;
    {bus4.a_less_b, bus4.a_equal_b, bus4.a_greater_b} = 3'b000;
    {bus1.a_less_b, bus1.a_equal_b, bus1.a_greater_b} = 3'b000;
    @(posedge clk);
    @(posedge clk);

    // Table: lock on EQUAL, then interrupted and completed LESS runs.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].s);
      act = {bus4.stable_valid, bus4.stable_less, bus4.stable_equal, bus4.stable_greater,
             bus4.change_pulse, bus4.change_count};
      check($sformatf("vec%0d", i), 32'(act),
            32'({tbl[i].e_valid, tbl[i].e_stable, tbl[i].e_pulse, tbl[i].e_count}));
    end

    // Long EQUAL run: saturation never re-triggers.
    drive(1'b1, 1'b0, CMP_LESS);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, CMP_EQUAL);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, CMP_EQUAL);
      check("sat_no_pulse", 32'(bus4.change_pulse), 32'd0);
    end
    check("sat_count", 32'(bus4.change_count), 32'd1);

    // Gap in valid samples keeps the run.
    drive(1'b1, 1'b0, CMP_LESS);
    drive(1'b0, 1'b1, CMP_LESS);
    drive(1'b0, 1'b1, CMP_LESS);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, CMP_GREATER);
    drive(1'b0, 1'b1, CMP_LESS);
    check("gap_not_yet", 32'(bus4.stable_valid), 32'd0);
    drive(1'b0, 1'b1, CMP_LESS);
    check("gap_lock", 32'({bus4.stable_valid, bus4.stable_less, bus4.change_pulse}), 32'b111);

    // Non-one-hot sample restarts the run.
    drive(1'b1, 1'b0, CMP_LESS);
    drive(1'b0, 1'b1, CMP_GREATER);
    drive(1'b0, 1'b1, CMP_GREATER);
    drive(1'b0, 1'b1, 3'b110);
`ifdef COMPARE_DEBOUNCE_ERR_EN
    check("err_set", 32'(bus4.err_flag), 32'd1);
`else
    check("err_off", 32'(bus4.err_flag), 32'd0);
`endif
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, CMP_GREATER);
    check("illegal_restart", 32'(bus4.stable_valid), 32'd0);
    drive(1'b0, 1'b1, CMP_GREATER);
    check("illegal_lock", 32'({bus4.stable_valid, bus4.stable_greater}), 32'b11);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, CMP_LESS);
`ifdef COMPARE_DEBOUNCE_ERR_EN
    check("err_sticky", 32'(bus4.err_flag), 32'd1);
`endif
    drive(1'b1, 1'b0, CMP_LESS);
    check("err_reset", 32'(bus4.err_flag), 32'd0);

    // Randomised runs, gaps, illegal samples and occasional resets.
    prev = CMP_EQUAL;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      if (r < 9) pick = prev;
      else if (r < 14) begin
        case ($urandom_range(0, 2))
          0:       pick = CMP_LESS;
          1:       pick = CMP_EQUAL;
          default: pick = CMP_GREATER;
        endcase
      end else pick = 3'($urandom_range(0, 7));
      prev = pick;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), pick);
    end

    // STABLE_COUNT=1: alternate LESS/GREATER, pulse every cycle, count saturates.
    drive(1'b1, 1'b0, CMP_LESS);
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, (i % 2 == 0) ? CMP_LESS : CMP_GREATER);
      check("alt_pulse", 32'(bus1.change_pulse), 32'd1);
    end
    check("alt_count_sat", 32'(bus1.change_count), 32'd255);
    drive(1'b1, 1'b1, CMP_LESS);
    check("midreset_sc1", 32'({bus1.stable_valid, bus1.stable_less, bus1.stable_equal,
          bus1.stable_greater, bus1.change_pulse, bus1.change_count, bus1.err_flag}), 32'd0);
    check("midreset_sc4", 32'({bus4.stable_valid, bus4.stable_less, bus4.stable_equal,
          bus4.stable_greater, bus4.change_pulse, bus4.change_count, bus4.err_flag}), 32'd0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? CMP_GREATER : CMP_LESS);
    check("post_reset_count", 32'(bus1.change_count), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
